countdown_sched: RTL and testbench

Round-robin scheduler that shares one 6-bit down-counter (din/ena/oflag interface) among NUM_REQ requesters. Each requester asks for a countdown of a given length; the scheduler grants one requester at a time, loads the counter, waits for its zero flag, and returns a one-cycle completion pulse. It sits between the control logic that needs timed intervals and the single counter instance, and is the only driver of the counter's din/ena.

---
 rtl/countdown_sched_if.sv | 30 +++
 rtl/countdown_sched.sv | 142 ++++++++++++++
 tb/tb_countdown_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_sched_if
//  Purpose  : Requester and counter signals of the countdown scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface countdown_sched_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req;
  logic [6*NUM_REQ-1:0] len;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic                 busy;
  logic [5:0]           cnt_din;
  logic                 cnt_ena;
  logic                 cnt_oflag;

  modport slave (
    input  req, len, cnt_oflag,
    output gnt, done, err, busy, cnt_din, cnt_ena
  );

  modport master (
    output req, len, cnt_oflag,
    input  gnt, done, err, busy, cnt_din, cnt_ena
  );
endinterface
`default_nettype wire

// File: rtl/countdown_sched.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_sched
//  Purpose  : Round-robin sharing of one 6-bit down-counter among requesters,
//             with a per-job watchdog that aborts a job whose zero flag never arrives.
//  Revision : 1.0  initial release
// ============================================================================
module countdown_sched #(
  parameter int NUM_REQ = 4,
  parameter int SLACK   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  countdown_sched_if.slave  io_bus
);

  localparam int                 c_IDX_W    = $clog2(NUM_REQ);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [5:0]           r_len, w_len_nxt;
  logic [6:0]           r_wdog, w_wdog_nxt;
  logic                 r_abort, w_abort_nxt;

  logic                 w_any_req;
  logic [c_IDX_W-1:0]   w_win_idx;
  logic [5:0]           w_win_len;
  logic [6:0]           w_wdog_inc;
  logic [6:0]           w_limit;
  logic [NUM_REQ-1:0]   w_idx_onehot;

  function automatic logic [c_IDX_W-1:0] rr_pos(input logic [c_IDX_W-1:0] base,
                                                input int off);
    int v_sum;
    v_sum = int'(base) + off;
    if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
    return c_IDX_W'(v_sum);
  endfunction

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    w_any_req = 1'b0;
    w_win_idx = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any_req && io_bus.req[rr_pos(r_ptr, k)]) begin
        w_win_idx = rr_pos(r_ptr, k);
        w_any_req = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_len    = 6'd0;
    w_idx_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == c_IDX_W'(i)) w_win_len = io_bus.len[6*i +: 6];
      w_idx_onehot[i] = (r_idx == c_IDX_W'(i));
    end
  end

  assign w_wdog_inc = r_wdog + 7'd1;
  assign w_limit    = {1'b0, r_len} + 7'(SLACK);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_len   <= 6'd0;
      r_wdog  <= 7'd0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_len   <= w_len_nxt;
      r_wdog  <= w_wdog_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_wdog_nxt  = r_wdog;
    w_abort_nxt = r_abort;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_idx_nxt   = w_win_idx;
          w_len_nxt   = w_win_len;
          w_abort_nxt = 1'b0;
          // A zero-length job never touches the counter.
          w_state_nxt = (w_win_len == 6'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_ARM;
      S_ARM: begin
        w_wdog_nxt  = 7'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.cnt_oflag) begin
          w_state_nxt = S_DONE;
        end else begin
          w_wdog_nxt = w_wdog_inc;
          if (w_wdog_inc == w_limit) begin
            w_abort_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_ptr_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign io_bus.busy    = (r_state != S_IDLE);
  assign io_bus.gnt     = (r_state != S_IDLE) ? w_idx_onehot : '0;
  assign io_bus.done    = (r_state == S_DONE) ? w_idx_onehot : '0;
  assign io_bus.err     = (r_state == S_DONE) && r_abort;
  assign io_bus.cnt_ena = (r_state == S_LOAD);
  assign io_bus.cnt_din = (r_state == S_LOAD) ? r_len : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_countdown_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_sched
//  Purpose  : Self-checking bench for countdown_sched: job-timeline model plus
//             directed literal checks and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_countdown_sched;
  localparam int N  = 4;
  localparam int SL = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  countdown_sched_if #(.NUM_REQ(N)) bus ();
  countdown_sched #(.NUM_REQ(N), .SLACK(SL)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  // Behavioural down-counter the scheduler drives.
  logic [5:0] cnt = 6'd0;
  int         ofl_mode = 0;
  logic       ofl_rnd  = 1'b0;
  always @(posedge clk) begin
    if (bus.cnt_ena) cnt <= bus.cnt_din;
    else if (cnt != 6'd0) cnt <= cnt - 6'd1;
  end
  assign bus.cnt_oflag = (ofl_mode == 0) ? (cnt == 6'd0) :
                         (ofl_mode == 2) ? ofl_rnd : 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Job timeline model: t counts cycles since arbitration, end is the DONE cycle.
  bit m_act = 0, m_abort = 0, chk_en = 0;
  int m_idx = 0, m_len = 0, m_t = 0, m_end = 0, m_ptr = 0;
  logic [N-1:0] e_gnt, e_done;
  logic         e_err, e_busy, e_ena;
  logic [5:0]   e_din;

  int ena_cnt = 0, ena_cyc = 0, ena_din = 0;
  int done_cnt = 0, done_cyc = 0, done_vec = 0, done_err = 0;
  logic [N-1:0] done_now = '0;

  always @(negedge clk) begin
    e_gnt = '0; e_done = '0; e_err = 1'b0; e_busy = 1'b0; e_ena = 1'b0; e_din = 6'd0;
    if (m_act) begin
      e_busy = 1'b1;
      if (m_len != 0 || m_t == m_end) e_gnt[m_idx] = 1'b1;
      e_ena = (m_t == 1) && (m_len != 0);
      e_din = e_ena ? 6'(m_len) : 6'd0;
      if (m_t == m_end) begin
        e_done[m_idx] = 1'b1;
        e_err = m_abort;
      end
    end
    if (chk_en) begin
      checks++;
      if ({bus.gnt, bus.done, bus.err, bus.busy, bus.cnt_ena, bus.cnt_din} !==
          {e_gnt, e_done, e_err, e_busy, e_ena, e_din}) begin
        errors++;
        $display("FAIL cycle %0d outputs: got gnt=%b done=%b err=%b busy=%b ena=%b din=%0d, expected gnt=%b done=%b err=%b busy=%b ena=%b din=%0d",
                 cyc, bus.gnt, bus.done, bus.err, bus.busy, bus.cnt_ena, bus.cnt_din,
                 e_gnt, e_done, e_err, e_busy, e_ena, e_din);
      end
    end
    done_now = bus.done;
    if (bus.cnt_ena === 1'b1) begin
      ena_cnt++; ena_cyc = cyc; ena_din = int'(bus.cnt_din);
    end
    if (|bus.done === 1'b1) begin
      done_cnt++; done_cyc = cyc; done_vec = int'(bus.done); done_err = int'(bus.err);
    end
    if (rstn == 1'b0) begin
      m_act = 0; m_ptr = 0; chk_en = 1;
    end else if (m_act) begin
      if (m_t == m_end) begin
        m_act = 0;
        m_ptr = (m_idx + 1) % N;
      end else begin
        if (m_t >= 3 && bus.cnt_oflag) m_end = m_t + 1;
        else if (m_t >= 3 && m_t == m_len + SL + 2) begin
          m_end = m_t + 1; m_abort = 1;
        end
        m_t++;
      end
    end else if (|bus.req) begin
      for (int k = N - 1; k >= 0; k--)
        if (bus.req[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
      m_len   = int'(bus.len[6*m_idx +: 6]);
      m_act   = 1; m_t = 1; m_abort = 0;
      m_end   = (m_len == 0) ? 1 : 1000;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_);
    checks++;
    if (act !== exp_) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_);
    end
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int s;
    s = done_cnt;
    for (int i = 0; i < maxc && done_cnt == s; i++) tick(1);
    checks++;
    if (done_cnt == s) begin
      errors++;
      $display("FAIL %s: no done pulse within %0d cycles", nm, maxc);
    end
  endtask

  int t0, e0, s0;

  initial begin
    bus.req = '0;
    bus.len = '0;
    tick(3);
    rstn = 1'b1;
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset gnt", 32'(bus.gnt), 0);
    chk("reset ena", 32'(bus.cnt_ena), 0);

    // Round robin from ptr 0 with all requesters held.
    bus.req = 4'b1111; bus.len = {4{6'd3}}; t0 = cyc;
    for (int j = 0; j < 5; j++) begin
      wait_done($sformatf("rr job %0d", j), 40);
      chk($sformatf("rr grant %0d", j), 32'(done_vec), 32'(1 << (j % 4)));
      if (j == 0) chk("rr first latency", 32'(done_cyc - t0), 6);
    end
    bus.req = '0;
    tick(2);

    // Single requester, len 8.
    bus.req = 4'b0001; bus.len[5:0] = 6'd8; t0 = cyc; e0 = ena_cnt;
    wait_done("single", 40);
    chk("single ena count", 32'(ena_cnt - e0), 1);
    chk("single ena latency", 32'(ena_cyc - t0), 1);
    chk("single din", 32'(ena_din), 8);
    chk("single done latency", 32'(done_cyc - t0), 11);
    chk("single done vec", 32'(done_vec), 1);
    chk("single err", 32'(done_err), 0);
    bus.req = '0;
    tick(2);

    // Pointer now 1: requester 1 beats requester 0.
    bus.req = 4'b0011; bus.len[11:0] = {6'd2, 6'd2};
    wait_done("ptr first", 40);
    chk("ptr winner", 32'(done_vec), 32'b0010);
    bus.req = 4'b0001;
    wait_done("ptr second", 40);
    chk("ptr second winner", 32'(done_vec), 32'b0001);
    bus.req = '0;
    tick(2);

    // Zero-length job.
    bus.req = 4'b0100; bus.len[17:12] = 6'd0; t0 = cyc; e0 = ena_cnt;
    wait_done("len0", 10);
    chk("len0 latency", 32'(done_cyc - t0), 1);
    chk("len0 vec", 32'(done_vec), 32'b0100);
    chk("len0 no ena", 32'(ena_cnt - e0), 0);
    bus.req = '0;
    tick(2);

    // Watchdog abort with the zero flag stuck low.
    ofl_mode = 1;
    bus.req = 4'b1000; bus.len[23:18] = 6'd5; t0 = cyc;
    wait_done("watchdog", 60);
    chk("wdog latency", 32'(done_cyc - t0), 12);
    chk("wdog err", 32'(done_err), 1);
    chk("wdog vec", 32'(done_vec), 32'b1000);
    bus.req = '0; ofl_mode = 0;
    tick(1);
    chk("wdog idle", 32'(bus.busy), 0);
    tick(2);

    // len and req changes mid-job are ignored.
    bus.req = 4'b0001; bus.len[5:0] = 6'd8; t0 = cyc; e0 = ena_cnt;
    tick(5);
    bus.len[5:0] = 6'd16; bus.req = '0;
    wait_done("midjob", 40);
    chk("midjob ena count", 32'(ena_cnt - e0), 1);
    chk("midjob latency", 32'(done_cyc - t0), 11);
    chk("midjob vec", 32'(done_vec), 1);
    tick(2);

    // Reset during WAIT.
    bus.req = 4'b0100; bus.len[17:12] = 6'd10; s0 = done_cnt;
    tick(5);
    rstn = 1'b0; bus.req = '0;
    tick(1);
    rstn = 1'b1;
    chk("midreset busy", 32'(bus.busy), 0);
    chk("midreset gnt", 32'(bus.gnt), 0);
    chk("midreset no done", 32'(done_cnt - s0), 0);
    bus.req = 4'b1001; bus.len[5:0] = 6'd1; bus.len[23:18] = 6'd1;
    wait_done("post reset", 40);
    chk("post reset ptr0", 32'(done_vec), 32'b0001);
    bus.req = 4'b0010; bus.len[11:6] = 6'd2;
    wait_done("post reset req1", 40);
    chk("post reset req1", 32'(done_vec), 32'b0010);
    bus.req = '0;
    tick(2);

    // Randomized traffic checked by the timeline model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) ofl_mode = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(0, 1)) * 2;
      ofl_rnd = ($urandom_range(0, 5) == 0);
      rstn    = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && done_now[i]) begin
          bus.req[i] = ($urandom_range(0, 3) == 0);
        end else if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b1;
          bus.len[6*i +: 6] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                         : 6'($urandom_range(0, 10));
        end else if ($urandom_range(0, 30) == 0) begin
          bus.len[6*i +: 6] = 6'($urandom_range(0, 63));
        end
      end
      tick(1);
    end
    rstn = 1'b1; bus.req = '0; ofl_mode = 0;
    tick(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
